// File: rtl/pc_sequencer.sv
// Program counter sequencer: holds the core in a boot delay after reset, then
// fetches sequentially or redirects on trap, trap return, jump or branch, and
// parks in HALT on request until the next reset.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned BOOT_DELAY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        trap_req,
  input  logic        mret,
  input  logic [31:0] mepc_in,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        retire,
  output logic [31:0] epc_out,
  output logic        misalign_trap,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    StBoot  = 2'b00,
    StFetch = 2'b01,
    StHalt  = 2'b10,
    StBad   = 2'b11
  } state_e;

  localparam logic [3:0] BootLast = 4'(BOOT_DELAY);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] epc_q;
  logic        misalign_q;
  logic [3:0]  boot_cnt_q;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic        redirect_chk;
  logic        misaligned;

  assign pc_plus4 = pc_q + 32'd4;

  // Non-trap next-PC select; only redirect targets are alignment-checked.
  always_comb begin
    redirect_pc  = pc_plus4;
    redirect_chk = 1'b0;
    if (mret) begin
      redirect_pc  = mepc_in;
      redirect_chk = 1'b1;
    end else if (jump) begin
      redirect_pc  = jump_target;
      redirect_chk = 1'b1;
    end else if (branch_taken) begin
      redirect_pc  = branch_target;
      redirect_chk = 1'b1;
    end
    misaligned = redirect_chk & (redirect_pc[1:0] != 2'b00);
  end

  // Sequencer FSM with PC, EPC and misalignment pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VECTOR;
      epc_q      <= 32'h0;
      misalign_q <= 1'b0;
      boot_cnt_q <= 4'h0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        StBoot: begin
          pc_q       <= RESET_VECTOR;
          boot_cnt_q <= boot_cnt_q + 4'd1;
          if (boot_cnt_q == BootLast) begin
            state_q <= StFetch;
          end
        end
        StFetch: begin
          // Without an acknowledge the PC holds and all redirects are ignored.
          if (imem_ready) begin
            if (trap_req) begin
              pc_q  <= TRAP_VECTOR;
              epc_q <= pc_q;
            end else if (misaligned) begin
              pc_q       <= TRAP_VECTOR;
              epc_q      <= pc_q;
              misalign_q <= 1'b1;
            end else begin
              pc_q <= redirect_pc;
            end
            if (halt_req) begin
              state_q <= StHalt;
            end
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q    <= StBoot;
          pc_q       <= RESET_VECTOR;
          boot_cnt_q <= 4'h0;
        end
      endcase
    end
  end

  assign pc            = pc_q;
  assign epc_out       = epc_q;
  assign misalign_trap = misalign_q;
  assign state         = state_q;
  assign imem_req      = (state_q == StFetch);
  assign retire        = imem_req & imem_ready;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each stimulus step pushes the expected
// post-edge state; it is popped and compared one cycle later.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ready, branch_taken, jump, trap_req, mret, halt_req;
  logic [31:0] branch_target, jump_target, mepc_in;
  logic [31:0] pc, epc_out, pc0, epc0;
  logic        imem_req, retire, misalign_trap, req0, ret0, mis0;
  logic [1:0]  state, state0;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        mis;
    logic [1:0]  st;
    logic        req;
  } exp_t;

  typedef struct {
    logic        rdy, br, jp, tr, mr, hl;
    logic [31:0] bt, jt, me;
    logic [31:0] xpc, xepc;
    logic        xmis, xret;
    logic [1:0]  xst;
  } step_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100),
    .BOOT_DELAY  (2)
  ) u_dut (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .trap_req(trap_req), .mret(mret), .mepc_in(mepc_in), .halt_req(halt_req),
    .pc(pc), .imem_req(imem_req), .retire(retire), .epc_out(epc_out),
    .misalign_trap(misalign_trap), .state(state)
  );

  pc_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100),
    .BOOT_DELAY  (0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .trap_req(trap_req), .mret(mret), .mepc_in(mepc_in), .halt_req(halt_req),
    .pc(pc0), .imem_req(req0), .retire(ret0), .epc_out(epc0),
    .misalign_trap(mis0), .state(state0)
  );

  function automatic step_t mk(input logic rdy, input logic br, input logic [31:0] bt,
                               input logic jp, input logic [31:0] jt, input logic tr,
                               input logic mr, input logic [31:0] me, input logic hl,
                               input logic [31:0] xpc, input logic [31:0] xepc,
                               input logic xmis, input logic [1:0] xst, input logic xret);
    step_t s;
    s.rdy = rdy; s.br = br; s.bt = bt; s.jp = jp; s.jt = jt; s.tr = tr;
    s.mr = mr; s.me = me; s.hl = hl;
    s.xpc = xpc; s.xepc = xepc; s.xmis = xmis; s.xst = xst; s.xret = xret;
    return s;
  endfunction

  // Drive one step's inputs and record what the DUT must show after the edge.
  task automatic apply(input step_t s);
    exp_t e;
    imem_ready = s.rdy; branch_taken = s.br; branch_target = s.bt;
    jump = s.jp; jump_target = s.jt; trap_req = s.tr; mret = s.mr;
    mepc_in = s.me; halt_req = s.hl;
    e.pc = s.xpc; e.epc = s.xepc; e.mis = s.xmis; e.st = s.xst;
    e.req = (s.xst == 2'b01);
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs;
    imem_ready = 0; branch_taken = 0; branch_target = 0; jump = 0; jump_target = 0;
    trap_req = 0; mret = 0; mepc_in = 0; halt_req = 0;
  endtask

  task automatic test_reset;
    exp_t e;
    exp_t got;
    rst = 1'b0;
    idle_inputs();
    #3;
    total++;
    if ({pc, epc_out, misalign_trap, state, imem_req, retire} !== {64'h0, 1'b0, 2'b00, 2'b00}) begin
      bad++;
      $display("FAIL reset_state got pc=%h epc=%h mis=%b st=%b req=%b ret=%b exp all zero",
               pc, epc_out, misalign_trap, state, imem_req, retire);
    end
    #9 rst = 1'b1;  // released at t=12, away from the edge
    for (int i = 0; i < 3; i++) begin
      e.pc = 32'h0; e.epc = 32'h0; e.mis = 1'b0;
      e.st = (i == 2) ? 2'b01 : 2'b00;
      e.req = (i == 2);
      exp_q.push_back(e);
      @(posedge clk); #1;
      got = exp_q.pop_front();
      total++;
      if ({pc, epc_out, misalign_trap, state, imem_req} !== got) begin
        bad++;
        $display("FAIL boot[%0d] got pc=%h st=%b req=%b exp pc=%h st=%b req=%b",
                 i, pc, state, imem_req, got.pc, got.st, got.req);
      end
      if (i == 0) begin
        total++;
        if (state0 !== 2'b01 || req0 !== 1'b1 || pc0 !== 32'h0) begin
          bad++;
          $display("FAIL boot_delay0 got st=%b req=%b pc=%h exp st=01 req=1 pc=0",
                   state0, req0, pc0);
        end
      end
    end
  endtask

  task automatic test_sequential_and_stall;
    step_t s[$];
    exp_t got;
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4,  0, 0, 2'b01, 1));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8,  0, 0, 2'b01, 1));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hC,  0, 0, 2'b01, 1));
    s.push_back(mk(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 32'hC,  0, 0, 2'b01, 0));
    s.push_back(mk(0, 1, 32'h40, 1, 32'h3, 1, 0, 0, 1, 32'hC, 0, 0, 2'b01, 0));
    s.push_back(mk(1, 1, 32'h40, 0, 0, 0, 0, 0, 0, 32'h40, 0, 0, 2'b01, 1));
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      total++;
      if (retire !== s[i].xret) begin
        bad++;
        $display("FAIL seq_retire[%0d] got=%b exp=%b", i, retire, s[i].xret);
      end
      @(posedge clk); #1;
      got = exp_q.pop_front();
      total++;
      if ({pc, epc_out, misalign_trap, state, imem_req} !== got) begin
        bad++;
        $display("FAIL seq_step[%0d] got pc=%h epc=%h mis=%b st=%b exp pc=%h epc=%h mis=%b st=%b",
                 i, pc, epc_out, misalign_trap, state, got.pc, got.epc, got.mis, got.st);
      end
    end
  endtask

  task automatic test_redirects;
    step_t s[$];
    exp_t got;
    // trap beats jump; mret returns; misaligned jump traps with a 1-cycle pulse
    s.push_back(mk(1, 0, 0, 1, 32'h80, 1, 0, 0, 0, 32'h100, 32'h40, 0, 2'b01, 1));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h44, 0, 32'h44, 32'h40, 0, 2'b01, 1));
    s.push_back(mk(1, 0, 0, 1, 32'h1002, 0, 0, 0, 0, 32'h100, 32'h44, 1, 2'b01, 1));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 32'h44, 0, 2'b01, 0));
    // priority mret > jump > branch, then a misaligned branch
    s.push_back(mk(1, 1, 32'h400, 1, 32'h300, 0, 1, 32'h200, 0, 32'h200, 32'h44, 0, 2'b01, 1));
    s.push_back(mk(1, 1, 32'h400, 1, 32'h300, 0, 0, 0, 0, 32'h300, 32'h44, 0, 2'b01, 1));
    s.push_back(mk(1, 1, 32'h401, 0, 0, 0, 0, 0, 0, 32'h100, 32'h300, 1, 2'b01, 1));
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      total++;
      if (retire !== s[i].xret) begin
        bad++;
        $display("FAIL redir_retire[%0d] got=%b exp=%b", i, retire, s[i].xret);
      end
      @(posedge clk); #1;
      got = exp_q.pop_front();
      total++;
      if ({pc, epc_out, misalign_trap, state, imem_req} !== got) begin
        bad++;
        $display("FAIL redir_step[%0d] got pc=%h epc=%h mis=%b st=%b exp pc=%h epc=%h mis=%b st=%b",
                 i, pc, epc_out, misalign_trap, state, got.pc, got.epc, got.mis, got.st);
      end
    end
  endtask

  task automatic test_halt;
    step_t s[$];
    exp_t got;
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h104, 32'h300, 0, 2'b10, 1));
    s.push_back(mk(1, 0, 0, 1, 32'h500, 1, 0, 0, 0, 32'h104, 32'h300, 0, 2'b10, 0));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 32'h300, 0, 2'b10, 0));
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      total++;
      if (retire !== s[i].xret) begin
        bad++;
        $display("FAIL halt_retire[%0d] got=%b exp=%b", i, retire, s[i].xret);
      end
      @(posedge clk); #1;
      got = exp_q.pop_front();
      total++;
      if ({pc, epc_out, misalign_trap, state, imem_req} !== got) begin
        bad++;
        $display("FAIL halt_step[%0d] got pc=%h st=%b req=%b exp pc=%h st=%b req=%b",
                 i, pc, state, imem_req, got.pc, got.st, got.req);
      end
    end
    // Asynchronous reset mid-HALT, checked before any clock edge.
    #3 rst = 1'b0;
    #1;
    total++;
    if ({pc, epc_out, misalign_trap, state, imem_req} !== {64'h0, 1'b0, 2'b00, 1'b0}) begin
      bad++;
      $display("FAIL async_reset got pc=%h epc=%h st=%b req=%b exp pc=0 epc=0 st=00 req=0",
               pc, epc_out, state, imem_req);
    end
    idle_inputs();
    #2 rst = 1'b1;
  endtask

  task automatic test_wrap_and_halt_trap;
    step_t s[$];
    exp_t got;
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (state === 2'b01) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL reboot_timeout got st=%b exp st=01 within 10 cycles", state);
    end
    s.push_back(mk(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 2'b01, 1));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'b01, 1));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0, 0, 2'b01, 1));
    s.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 32'h100, 32'h4, 0, 2'b10, 1));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 32'h4, 0, 2'b10, 0));
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      total++;
      if (retire !== s[i].xret) begin
        bad++;
        $display("FAIL wrap_retire[%0d] got=%b exp=%b", i, retire, s[i].xret);
      end
      @(posedge clk); #1;
      got = exp_q.pop_front();
      total++;
      if ({pc, epc_out, misalign_trap, state, imem_req} !== got) begin
        bad++;
        $display("FAIL wrap_step[%0d] got pc=%h epc=%h st=%b exp pc=%h epc=%h st=%b",
                 i, pc, epc_out, state, got.pc, got.epc, got.st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential_and_stall();
    test_redirects();
    test_halt();
    test_wrap_and_halt_trap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
